// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-stage request and hazard-control response bundle
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  ex_branch_taken;
  logic                  stall_if_id;
  logic                  bubble_id_ex;
  logic                  flush_if_id;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [CNT_W-1:0]      stall_cycles;

  // Pipeline side: presents the ID instruction, consumes the controls
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    input  stall_if_id, bubble_id_ex, flush_if_id,
           fwd_a_sel, fwd_b_sel, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    output stall_if_id, bubble_id_ex, flush_if_id,
           fwd_a_sel, fwd_b_sel, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage hazard/forwarding controller; HAZARD_FWD_EN enables forwarding
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  // What the EX-stage scoreboard entry holds this cycle
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sb_ex_valid_q, sb_ex_valid_d;
  logic [REG_ADDR_W-1:0] sb_ex_rd_q, sb_ex_rd_d;
  logic                  sb_ex_load_q, sb_ex_load_d;
  logic                  sb_mem_valid_q, sb_mem_valid_d;
  logic [REG_ADDR_W-1:0] sb_mem_rd_q, sb_mem_rd_d;
  logic                  sb_mem_load_q, sb_mem_load_d;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic ex_live;
  logic m_ex_a, m_ex_b, m_mem_a, m_mem_b;
  logic hazard;
  logic stall, bubble, flush;
  logic unused_load;

  // The load bit only matters while the producer is in EX
  assign unused_load = sb_ex_load_q ^ sb_mem_load_q;

  // SB_EX only carries an instruction after an issue cycle; stall and
  // flush cycles always leave a bubble behind in EX
  assign ex_live = sb_ex_valid_q && (state_q == ST_RUN);

  // Source matches; x0 and unread operands never create a dependency
  always_comb begin
    m_ex_a  = ex_live && (sb_ex_rd_q == bus.id_rs1) &&
              (bus.id_rs1 != '0) && bus.id_rs1_used;
    m_ex_b  = ex_live && (sb_ex_rd_q == bus.id_rs2) &&
              (bus.id_rs2 != '0) && bus.id_rs2_used;
    m_mem_a = sb_mem_valid_q && (sb_mem_rd_q == bus.id_rs1) &&
              (bus.id_rs1 != '0) && bus.id_rs1_used;
    m_mem_b = sb_mem_valid_q && (sb_mem_rd_q == bus.id_rs2) &&
              (bus.id_rs2 != '0) && bus.id_rs2_used;
`ifdef HAZARD_FWD_EN
    hazard  = (m_ex_a || m_ex_b) && sb_ex_load_q;
`else
    hazard  = m_ex_a || m_ex_b || m_mem_a || m_mem_b;
`endif
  end

  // Flush beats stall beats issue; computes controls and next state
  always_comb begin
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    state_d = ST_RUN;
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    cnt_d   = cnt_q;
    if (bus.ex_branch_taken) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = ST_FLUSH;
    end else if (bus.id_valid && hazard) begin
      stall   = 1'b1;
      bubble  = 1'b1;
      state_d = ST_LOAD_USE;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
`ifdef HAZARD_FWD_EN
      // Newest producer wins: EX/MEM before MEM/WB
      if (m_ex_a)       fwd_a_d = 2'b01;
      else if (m_mem_a) fwd_a_d = 2'b10;
      if (m_ex_b)       fwd_b_d = 2'b01;
      else if (m_mem_b) fwd_b_d = 2'b10;
`endif
    end
    sb_ex_valid_d  = bus.id_valid && bus.id_reg_write && !bubble;
    sb_ex_rd_d     = bus.id_rd;
    sb_ex_load_d   = bus.id_mem_read;
    sb_mem_valid_d = sb_ex_valid_q;
    sb_mem_rd_d    = sb_ex_rd_q;
    sb_mem_load_d  = sb_ex_load_q;
  end

  // Scoreboard, state, forwarding selects and stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      sb_ex_valid_q  <= 1'b0;
      sb_ex_rd_q     <= '0;
      sb_ex_load_q   <= 1'b0;
      sb_mem_valid_q <= 1'b0;
      sb_mem_rd_q    <= '0;
      sb_mem_load_q  <= 1'b0;
      fwd_a_q        <= 2'b00;
      fwd_b_q        <= 2'b00;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      sb_ex_valid_q  <= sb_ex_valid_d;
      sb_ex_rd_q     <= sb_ex_rd_d;
      sb_ex_load_q   <= sb_ex_load_d;
      sb_mem_valid_q <= sb_mem_valid_d;
      sb_mem_rd_q    <= sb_mem_rd_d;
      sb_mem_load_q  <= sb_mem_load_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.stall_if_id  = stall;
  assign bus.bubble_id_ex = bubble;
  assign bus.flush_if_id  = flush;
  assign bus.fwd_a_sel    = fwd_a_q;
  assign bus.fwd_b_sel    = fwd_b_q;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(8))  sbus ();

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(8)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  assign sbus.id_valid        = bus.id_valid;
  assign sbus.id_rs1          = bus.id_rs1;
  assign sbus.id_rs2          = bus.id_rs2;
  assign sbus.id_rs1_used     = bus.id_rs1_used;
  assign sbus.id_rs2_used     = bus.id_rs2_used;
  assign sbus.id_rd           = bus.id_rd;
  assign sbus.id_reg_write    = bus.id_reg_write;
  assign sbus.id_mem_read     = bus.id_mem_read;
  assign sbus.ex_branch_taken = bus.ex_branch_taken;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs, cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic instr_t nop();
    instr_t t = '0;
    return t;
  endfunction

  function automatic instr_t alu(int rd, int rs1, int rs2);
    instr_t t = '0;
    t.v = 1'b1; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0];
    t.u1 = 1'b1; t.u2 = 1'b1; t.rd = rd[4:0]; t.rw = 1'b1;
    return t;
  endfunction

  function automatic instr_t ld(int rd, int rs1);
    instr_t t = '0;
    t.v = 1'b1; t.rs1 = rs1[4:0]; t.u1 = 1'b1;
    t.rd = rd[4:0]; t.rw = 1'b1; t.mr = 1'b1;
    return t;
  endfunction

  function automatic exp_t xp(int s, int b, int f, int fa, int fb, int cnt);
    exp_t r;
    r.stall = s[0]; r.bubble = b[0]; r.flush = f[0];
    r.fa = fa[1:0]; r.fb = fb[1:0]; r.cnt = cnt[15:0];
    return r;
  endfunction

  task automatic drive(input instr_t i);
    bus.id_valid        = i.v;
    bus.id_rs1          = i.rs1;
    bus.id_rs2          = i.rs2;
    bus.id_rs1_used     = i.u1;
    bus.id_rs2_used     = i.u2;
    bus.id_rd           = i.rd;
    bus.id_reg_write    = i.rw;
    bus.id_mem_read     = i.mr;
    bus.ex_branch_taken = i.br;
  endtask

  // One pipeline cycle: drive ID, queue the expectation, sample controls
  // mid-cycle and registered outputs just after the edge
  task automatic cycle(input instr_t i, input exp_t e);
    drive(i);
    exp_q.push_back(e);
    @(negedge clk);
    obs.stall  = bus.stall_if_id;
    obs.bubble = bus.bubble_id_ex;
    obs.flush  = bus.flush_if_id;
    @(posedge clk);
    #1;
    obs.fa  = bus.fwd_a_sel;
    obs.fb  = bus.fwd_b_sel;
    obs.cnt = bus.stall_cycles;
    cur = exp_q.pop_front();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(nop());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(alu(6, 5, 1));
    #1;
    exp_q.push_back(xp(0, 0, 0, 0, 0, 0));
    obs = {bus.stall_if_id, bus.bubble_id_ex, bus.flush_if_id,
           bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_cycles};
    cur = exp_q.pop_front();
    n_cmp++;
    if (obs !== cur) begin
      n_bad++;
      $display("FAIL reset_state got %h want %h", obs, cur);
    end
    do_reset();
    cycle(nop(), xp(0, 0, 0, 0, 0, 0));
    n_cmp++;
    if (obs !== cur) begin
      n_bad++;
      $display("FAIL reset_idle got %h want %h", obs, cur);
    end
  endtask

  task automatic test_fwd_ex();
    instr_t p[$];
    exp_t   e[$];
    do_reset();
`ifdef HAZARD_FWD_EN
    p = '{alu(5, 1, 2), alu(6, 5, 1), nop()};
    e = '{xp(0,0,0,0,0,0), xp(0,0,0,1,0,0), xp(0,0,0,0,0,0)};
`else
    p = '{alu(5, 1, 2), alu(6, 5, 1), alu(6, 5, 1), alu(6, 5, 1), nop()};
    e = '{xp(0,0,0,0,0,0), xp(1,1,0,0,0,1), xp(1,1,0,0,0,2),
          xp(0,0,0,0,0,2), xp(0,0,0,0,0,2)};
`endif
    for (int i = 0; i < p.size(); i++) begin
      cycle(p[i], e[i]);
      n_cmp++;
      if (obs !== cur) begin
        n_bad++;
        $display("FAIL fwd_ex[%0d] got %h want %h", i, obs, cur);
      end
    end
  endtask

  task automatic test_fwd_mem();
    instr_t p[$];
    exp_t   e[$];
    do_reset();
`ifdef HAZARD_FWD_EN
    p = '{alu(5, 1, 2), nop(), alu(6, 5, 1)};
    e = '{xp(0,0,0,0,0,0), xp(0,0,0,0,0,0), xp(0,0,0,2,0,0)};
`else
    p = '{alu(5, 1, 2), nop(), alu(6, 5, 1), alu(6, 5, 1)};
    e = '{xp(0,0,0,0,0,0), xp(0,0,0,0,0,0), xp(1,1,0,0,0,1), xp(0,0,0,0,0,1)};
`endif
    for (int i = 0; i < p.size(); i++) begin
      cycle(p[i], e[i]);
      n_cmp++;
      if (obs !== cur) begin
        n_bad++;
        $display("FAIL fwd_mem[%0d] got %h want %h", i, obs, cur);
      end
    end
  endtask

  task automatic test_load_use();
    instr_t p[$];
    exp_t   e[$];
    do_reset();
`ifdef HAZARD_FWD_EN
    p = '{ld(7, 1), alu(8, 7, 7), alu(8, 7, 7)};
    e = '{xp(0,0,0,0,0,0), xp(1,1,0,0,0,1), xp(0,0,0,2,2,1)};
`else
    p = '{ld(7, 1), alu(8, 7, 7), alu(8, 7, 7), alu(8, 7, 7)};
    e = '{xp(0,0,0,0,0,0), xp(1,1,0,0,0,1), xp(1,1,0,0,0,2), xp(0,0,0,0,0,2)};
`endif
    for (int i = 0; i < p.size(); i++) begin
      cycle(p[i], e[i]);
      n_cmp++;
      if (obs !== cur) begin
        n_bad++;
        $display("FAIL load_use[%0d] got %h want %h", i, obs, cur);
      end
    end
  endtask

  task automatic test_x0();
    instr_t p[$];
    instr_t t;
    do_reset();
    t = alu(11, 3, 5);
    t.u2 = 1'b0;
    p = '{alu(0, 1, 2), alu(9, 0, 0), alu(5, 1, 2), t};
    for (int i = 0; i < p.size(); i++) begin
      cycle(p[i], xp(0, 0, 0, 0, 0, 0));
      n_cmp++;
      if (obs !== cur) begin
        n_bad++;
        $display("FAIL x0_unused[%0d] got %h want %h", i, obs, cur);
      end
    end
  endtask

  task automatic test_branch_hazard();
    instr_t p[$];
    exp_t   e[$];
    instr_t t;
    do_reset();
    t = alu(8, 7, 7);
    t.br = 1'b1;
    p = '{ld(7, 1), t, alu(8, 7, 7)};
`ifdef HAZARD_FWD_EN
    e = '{xp(0,0,0,0,0,0), xp(0,1,1,0,0,0), xp(0,0,0,2,2,0)};
`else
    e = '{xp(0,0,0,0,0,0), xp(0,1,1,0,0,0), xp(1,1,0,0,0,1)};
`endif
    for (int i = 0; i < p.size(); i++) begin
      cycle(p[i], e[i]);
      n_cmp++;
      if (obs !== cur) begin
        n_bad++;
        $display("FAIL branch_hazard[%0d] got %h want %h", i, obs, cur);
      end
    end
  endtask

  task automatic test_back_to_back();
    instr_t p[$];
    exp_t   e[$];
    do_reset();
`ifdef HAZARD_FWD_EN
    p = '{alu(5, 1, 2), alu(5, 5, 1), alu(7, 5, 5), alu(9, 7, 5)};
    e = '{xp(0,0,0,0,0,0), xp(0,0,0,1,0,0), xp(0,0,0,1,1,0), xp(0,0,0,1,2,0)};
`else
    p = '{alu(5, 1, 2), alu(5, 5, 1), alu(5, 5, 1), alu(5, 5, 1),
          alu(7, 5, 5), alu(7, 5, 5), alu(7, 5, 5)};
    e = '{xp(0,0,0,0,0,0), xp(1,1,0,0,0,1), xp(1,1,0,0,0,2), xp(0,0,0,0,0,2),
          xp(1,1,0,0,0,3), xp(1,1,0,0,0,4), xp(0,0,0,0,0,4)};
`endif
    for (int i = 0; i < p.size(); i++) begin
      cycle(p[i], e[i]);
      n_cmp++;
      if (obs !== cur) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got %h want %h", i, obs, cur);
      end
    end
  endtask

  task automatic test_reset_mid();
    instr_t p[$];
    exp_t   e[$];
    do_reset();
    p = '{ld(7, 1), alu(8, 7, 7), alu(8, 7, 7), ld(9, 1)};
`ifdef HAZARD_FWD_EN
    e = '{xp(0,0,0,0,0,0), xp(1,1,0,0,0,1), xp(0,0,0,2,2,1), xp(0,0,0,0,0,1)};
`else
    e = '{xp(0,0,0,0,0,0), xp(1,1,0,0,0,1), xp(1,1,0,0,0,2), xp(0,0,0,0,0,2)};
`endif
    for (int i = 0; i < p.size(); i++) begin
      cycle(p[i], e[i]);
      n_cmp++;
      if (obs !== cur) begin
        n_bad++;
        $display("FAIL reset_mid_pre[%0d] got %h want %h", i, obs, cur);
      end
    end
    drive(alu(10, 9, 9));
    @(negedge clk);
    n_cmp++;
    if (bus.stall_if_id !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_stall got %b want 1", bus.stall_if_id);
    end
    reset = 1'b0;
    #1;
    exp_q.push_back(xp(0, 0, 0, 0, 0, 0));
    obs = {bus.stall_if_id, bus.bubble_id_ex, bus.flush_if_id,
           bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_cycles};
    cur = exp_q.pop_front();
    n_cmp++;
    if (obs !== cur) begin
      n_bad++;
      $display("FAIL reset_mid_async got %h want %h", obs, cur);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(nop(), xp(0, 0, 0, 0, 0, 0));
    n_cmp++;
    if (obs !== cur) begin
      n_bad++;
      $display("FAIL reset_mid_run got %h want %h", obs, cur);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(ld(7, 7));
`ifdef HAZARD_FWD_EN
    exp_q.push_back(xp(0, 0, 0, 0, 0, 300));
`else
    exp_q.push_back(xp(0, 0, 0, 0, 0, 400));
`endif
    repeat (600) @(posedge clk);
    #1;
    cur = exp_q.pop_front();
    n_cmp++;
    if (bus.stall_cycles !== cur.cnt) begin
      n_bad++;
      $display("FAIL stall_count got %0d want %0d", bus.stall_cycles, cur.cnt);
    end
    n_cmp++;
    if (sbus.stall_cycles !== 8'hFF) begin
      n_bad++;
      $display("FAIL stall_saturate got %h want ff", sbus.stall_cycles);
    end
    drive(nop());
  endtask

  initial begin
    reset = 1'b0;
    drive(nop());
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_x0();
    test_branch_hazard();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
